// File: rtl/cmp_result_filter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmp_result_filter_if : comparator flags in, filtered decision out        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface cmp_result_filter_if #(
   parameter int CNT_W = 3
);
   logic             clear;
   logic             in_valid;
   logic             a_less_b;
   logic             a_equal_b;
   logic             a_greater_b;
   logic             stable_valid;
   logic             stable_lt;
   logic             stable_eq;
   logic             stable_gt;
   logic             change_pulse;
   logic             err_pulse;
   logic [CNT_W-1:0] run_cnt;

   modport master (
      output clear, in_valid, a_less_b, a_equal_b, a_greater_b,
      input  stable_valid, stable_lt, stable_eq, stable_gt,
             change_pulse, err_pulse, run_cnt
   );

   modport slave (
      input  clear, in_valid, a_less_b, a_equal_b, a_greater_b,
      output stable_valid, stable_lt, stable_eq, stable_gt,
             change_pulse, err_pulse, run_cnt
   );
endinterface
`default_nettype wire

// File: rtl/cmp_result_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmp_result_filter : persistence filter over one-hot comparator flags     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cmp_result_filter #(
   parameter int PERSIST = 4,
   parameter int CNT_W   = 3
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   cmp_result_filter_if.slave  bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_TRACK  = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;

   localparam logic [CNT_W-1:0] c_persist = CNT_W'(PERSIST);
   localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

   logic [1:0]       r_state,        w_state_nxt;
   logic [2:0]       r_cand,         w_cand_nxt;
   logic [2:0]       r_stable,       w_stable_nxt;
   logic             r_stable_valid, w_stable_valid_nxt;
   logic             r_change,       w_change_nxt;
   logic             r_err,          w_err_nxt;
   logic [CNT_W-1:0] r_run_cnt,      w_run_cnt_nxt;

   logic [2:0]       w_sample;
   logic             w_legal;
   logic             w_lock;
   logic [CNT_W-1:0] w_cnt_inc;

   // Sample and decisions share the {gt, eq, lt} bit order.
   assign w_sample  = {bus.a_greater_b, bus.a_equal_b, bus.a_less_b};
   assign w_legal   = (w_sample == 3'b001) || (w_sample == 3'b010) || (w_sample == 3'b100);
   assign w_cnt_inc = r_run_cnt + c_one;

   always_comb begin
      w_state_nxt        = r_state;
      w_cand_nxt         = r_cand;
      w_stable_nxt       = r_stable;
      w_stable_valid_nxt = r_stable_valid;
      w_run_cnt_nxt      = r_run_cnt;
      w_change_nxt       = 1'b0;
      w_err_nxt          = 1'b0;
      w_lock             = 1'b0;

      if (bus.clear) begin
         w_state_nxt        = S_IDLE;
         w_cand_nxt         = 3'b000;
         w_stable_nxt       = 3'b000;
         w_stable_valid_nxt = 1'b0;
         w_run_cnt_nxt      = '0;
      end else if (bus.in_valid) begin
         if (!w_legal) begin
            // A locked decision survives a bad sample; only the run is lost.
            w_err_nxt     = 1'b1;
            w_run_cnt_nxt = '0;
            w_cand_nxt    = 3'b000;
            if (r_state == S_TRACK) begin
               w_state_nxt = S_IDLE;
            end
         end else if ((r_state == S_LOCKED) && (w_sample == r_stable)) begin
            w_run_cnt_nxt = (r_run_cnt >= c_persist) ? c_persist : w_cnt_inc;
         end else if ((r_state == S_TRACK) && (w_sample == r_cand)) begin
            w_run_cnt_nxt = w_cnt_inc;
            w_lock        = (w_cnt_inc == c_persist);
         end else begin
            w_cand_nxt    = w_sample;
            w_run_cnt_nxt = c_one;
            w_state_nxt   = S_TRACK;
            w_lock        = (PERSIST == 1);
         end

         // Whenever a lock happens the candidate equals the current sample.
         if (w_lock) begin
            w_change_nxt       = !r_stable_valid || (r_stable != w_sample);
            w_stable_nxt       = w_sample;
            w_stable_valid_nxt = 1'b1;
            w_state_nxt        = S_LOCKED;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_cand         <= 3'b000;
         r_stable       <= 3'b000;
         r_stable_valid <= 1'b0;
         r_change       <= 1'b0;
         r_err          <= 1'b0;
         r_run_cnt      <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_cand         <= w_cand_nxt;
         r_stable       <= w_stable_nxt;
         r_stable_valid <= w_stable_valid_nxt;
         r_change       <= w_change_nxt;
         r_err          <= w_err_nxt;
         r_run_cnt      <= w_run_cnt_nxt;
      end
   end

   assign bus.stable_valid = r_stable_valid;
   assign bus.stable_lt    = r_stable[0];
   assign bus.stable_eq    = r_stable[1];
   assign bus.stable_gt    = r_stable[2];
   assign bus.change_pulse = r_change;
   assign bus.err_pulse    = r_err;
   assign bus.run_cnt      = r_run_cnt;
endmodule
`default_nettype wire
